// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t        : controller states (IDLE, RUN, DONE)
//   booth_digit_t  : recoded radix-4 Booth digit in {-2,-1,0,+1,+2}
//   num_iter()     : number of Booth steps needed for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Operands are extended to width+2 bits, so width/2+1 radix-4 digits
  // cover the whole extended multiplier.
  function automatic int num_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder.
//   window : {b[2i+1], b[2i], b[2i-1]} multiplier bit triplet
//   digit  : recoded digit in {-2,-1,0,+1,+2}
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  always_comb begin
    digit = ZERO;
    case (window)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : request, taken only when not busy (IDLE or DONE)
//   mode_signed  : 1 = two's complement operands, 0 = unsigned
//   A, B         : multiplicand / multiplier, latched with start
//   busy         : high while the multiply is iterating
//   done         : one-cycle pulse, P valid in that cycle
//   P            : 2*WIDTH product, held until the next accepted start
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : gen_bad_width
      $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int N     = num_iter(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [ACC_W-1:0]   mcand_reg;   // multiplicand, pre-shifted by 2i
  logic [EXT_W-1:0]   mplier_reg;  // multiplier, consumed 2 bits per step
  logic               prev_reg;    // b[2i-1] for the current window
  logic [ACC_W-1:0]   acc_reg;

  // Extension with the mode folded into the fill bit: one datapath for both.
  logic               a_fill;
  logic               b_fill;
  logic [ACC_W-1:0]   a_ext;
  logic [EXT_W-1:0]   b_ext;

  assign a_fill = mode_signed & A[WIDTH-1];
  assign b_fill = mode_signed & B[WIDTH-1];
  assign a_ext  = {{(ACC_W - WIDTH){a_fill}}, A};
  assign b_ext  = {{(EXT_W - WIDTH){b_fill}}, B};

  booth_digit_t digit;

  booth_r4_encoder u_encoder (
    .window ({mplier_reg[1:0], prev_reg}),
    .digit  (digit)
  );

  // Negative digits use the inverted operand plus a carry-in, so the whole
  // step is a single adder.
  logic [ACC_W-1:0] addend;
  logic             carry_in;
  logic [ACC_W-1:0] sum;

  always_comb begin
    addend   = '0;
    carry_in = 1'b0;
    case (digit)
      POS1: addend = mcand_reg;
      POS2: addend = mcand_reg << 1;
      NEG1: begin
        addend   = ~mcand_reg;
        carry_in = 1'b1;
      end
      NEG2: begin
        addend   = ~(mcand_reg << 1);
        carry_in = 1'b1;
      end
      default: begin
        addend   = '0;
        carry_in = 1'b0;
      end
    endcase
  end

  assign sum = acc_reg + addend + {{(ACC_W - 1){1'b0}}, carry_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prev_reg   <= 1'b0;
      acc_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      P          <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            state_reg  <= RUN;
            busy       <= 1'b1;
            count_reg  <= '0;
            mcand_reg  <= a_ext;
            mplier_reg <= b_ext;
            prev_reg   <= 1'b0;
            acc_reg    <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg    <= sum;
          mcand_reg  <= mcand_reg << 2;
          // Arithmetic shift: the top bit already carries the extension.
          mplier_reg <= {{2{mplier_reg[EXT_W-1]}}, mplier_reg[EXT_W-1:2]};
          prev_reg   <= mplier_reg[1];
          count_reg  <= count_reg + CNT_W'(1);
          if (count_reg == LAST) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            P         <= sum[2*WIDTH-1:0];
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench: a WIDTH=32 and a WIDTH=8 instance, each shadowed by a
// cycle-level behavioural model (product from plain '*', timing from the
// start/done rules), compared every cycle, plus literal expectations.
module tb_seq_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0, mode32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] p32;

  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode_signed(mode32),
    .A(a32), .B(b32), .busy(busy32), .done(done32), .P(p32)
  );

  seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode_signed(mode8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .P(p8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: extend both operands to 64 bits, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn, input int w);
    logic [63:0] m, ae, be, pr;
    m  = (64'd1 << w) - 64'd1;
    ae = {32'b0, a} & m;
    be = {32'b0, b} & m;
    if (sgn && a[w-1]) ae = ae | ~m;
    if (sgn && b[w-1]) be = be | ~m;
    pr = ae * be;
    if (w < 32) pr = pr & ((64'd1 << (2 * w)) - 64'd1);
    return pr;
  endfunction

  // Behavioural models: accept when idle, result appears N edges later.
  localparam int N32 = 17;
  localparam int N8  = 5;
  bit          m_busy32 = 0, m_done32 = 0, m_busy8 = 0, m_done8 = 0;
  int          m_left32 = 0, m_left8 = 0;
  logic [63:0] m_p32 = '0, m_exp32 = '0, m_p8 = '0, m_exp8 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy32 = 0; m_done32 = 0; m_p32 = '0; m_left32 = 0;
      m_busy8  = 0; m_done8  = 0; m_p8  = '0; m_left8  = 0;
    end else begin
      m_done32 = 0;
      if (m_busy32) begin
        m_left32--;
        if (m_left32 == 0) begin m_busy32 = 0; m_done32 = 1; m_p32 = m_exp32; end
      end else if (start32) begin
        m_busy32 = 1; m_left32 = N32; m_exp32 = ref_mul(a32, b32, mode32, 32);
      end
      m_done8 = 0;
      if (m_busy8) begin
        m_left8--;
        if (m_left8 == 0) begin m_busy8 = 0; m_done8 = 1; m_p8 = m_exp8; end
      end else if (start8) begin
        m_busy8 = 1; m_left8 = N8; m_exp8 = ref_mul({24'b0, a8}, {24'b0, b8}, mode8, 8);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32", {63'b0, busy32}, {63'b0, m_busy32});
      chk("done32", {63'b0, done32}, {63'b0, m_done32});
      chk("p32", p32, m_p32);
      chk("busy8", {63'b0, busy8}, {63'b0, m_busy8});
      chk("done8", {63'b0, done8}, {63'b0, m_done8});
      chk("p8", {48'b0, p8}, m_p8);
    end
  end

  // Drive a request for one cycle; returns at the negedge of RUN cycle 1.
  task automatic launch(input int inst, input logic [31:0] a, input logic [31:0] b, input bit sgn);
    @(negedge clk);
    if (inst == 0) begin start32 = 1'b1; a32 = a; b32 = b; mode32 = sgn; end
    else begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; mode8 = sgn; end
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts cycles after the accepting edge.
  task automatic wait_done(input int inst, inout int lat, output logic [63:0] p);
    while (!((inst == 0) ? done32 : done8) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {63'b0, ((inst == 0) ? done32 : done8)}, 64'd1);
    p = (inst == 0) ? p32 : {48'b0, p8};
  endtask

  task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, output logic [63:0] p, output int lat);
    launch(inst, a, b, sgn);
    lat = 1;
    wait_done(inst, lat, p);
    $display("op w=%0d A=%h B=%h signed=%0d P=%h latency=%0d",
             (inst == 0) ? 32 : 8, a, b, sgn, p, lat);
  endtask

  logic [31:0] tab_a   [6] = '{32'd10, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
  logic [31:0] tab_b   [6] = '{32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
  bit          tab_s   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] tab_p   [6] = '{64'hFFFFFFFFFFFFFFCE, 64'h3FFFFFFF00000001, 64'h4000000000000000,
                               64'hFFFFFFFE00000001, 64'h0000000000000001, 64'h0};

  initial begin
    logic [63:0] p;
    int lat;
    int saw_done;

    // Model pinned to hand-computed values.
    chk("model_min_min", ref_mul(32'h80000000, 32'h80000000, 1'b1, 32), 64'h4000000000000000);
    chk("model_umax", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32), 64'hFFFFFFFE00000001);
    chk("model_8s", ref_mul(32'h80, 32'h80, 1'b1, 8), 64'h4000);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", {63'b0, busy32}, 64'd0);
    chk("reset_done", {63'b0, done32}, 64'd0);
    chk("reset_p", p32, 64'd0);
    rst = 1'b0;

    // Directed WIDTH=32 vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(0, tab_a[i], tab_b[i], tab_s[i], p, lat);
      chk("dir_p", p, tab_p[i]);
      chk("dir_latency", 64'(lat), 64'd18);
    end

    // Back-to-back with start held high.
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd50000; b32 = 32'd50000; mode32 = 1'b1;
    @(negedge clk);
    a32 = 32'd100000; b32 = -32'sd50000;
    lat = 1;
    wait_done(0, lat, p);
    $display("op held#1 P=%h latency=%0d", p, lat);
    chk("b2b_p1", p, 64'd2500000000);
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    wait_done(0, lat, p);
    $display("op held#2 P=%h spacing=%0d", p, lat);
    chk("b2b_p2", p, 64'hFFFFFFFED5FA0E00);
    chk("b2b_spacing", 64'(lat), 64'd18);

    // Start toggled and operands changed mid-run: no effect.
    launch(0, 32'd3, 32'd4, 1'b1);
    repeat (2) @(negedge clk);
    start32 = 1'b1; a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D; mode32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    lat = 4;
    wait_done(0, lat, p);
    $display("op disturbed P=%h latency=%0d", p, lat);
    chk("disturb_p", p, 64'd12);
    chk("disturb_latency", 64'(lat), 64'd18);

    // Reset in RUN cycle 5 aborts the multiply.
    launch(0, 32'd9, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy32}, 64'd0);
    chk("abort_p", p32, 64'd0);
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done32) saw_done++;
    end
    $display("op aborted, done pulses afterwards=%0d", saw_done);
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run_op(0, 32'd7, -32'sd6, 1'b1, p, lat);
    chk("after_abort_p", p, 64'hFFFFFFFFFFFFFFD6);

    // WIDTH=8 instance: literals, then random pairs in both modes.
    run_op(1, 32'h80, 32'h80, 1'b1, p, lat);
    chk("w8_min_min", p, 64'h4000);
    chk("w8_latency", 64'(lat), 64'd6);
    run_op(1, 32'hFF, 32'hFF, 1'b0, p, lat);
    chk("w8_umax", p, 64'hFE01);
    run_op(1, 32'hFF, 32'hFF, 1'b1, p, lat);
    chk("w8_neg1", p, 64'h0001);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(1, $urandom_range(255, 0), $urandom_range(255, 0), m[0], p, lat);
        chk("w8_rand_latency", 64'(lat), 64'd6);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
